bridge_top: RTL and testbench

AHB-Lite to APB bridge that sits between the AHB master and up to three APB peripherals. It registers the AHB address/data pipeline and decodes the peripheral select. An APB controller FSM then issues two-phase APB transfers (SETUP, ENABLE), stretching AHB with `Hreadyout` low while each APB SETUP phase runs. Read data passes straight back to AHB.

---
 rtl/bridge_pkg.sv | 24 ++
 rtl/bridge_if.sv | 25 ++
 rtl/bridge_ahb_slave_if.sv | 35 +++
 rtl/bridge_apb_controller.sv | 75 +++++++
 rtl/bridge_top.sv | 27 ++
 tb/tb_bridge_top.sv | 146 ++++++++++++++
 6 files changed

// File: rtl/bridge_pkg.sv
// bridge_pkg: shared AHB encodings, APB slave address map and controller states
package bridge_pkg;
  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [31:0] S0_LO = 32'h8000_0000;
  localparam logic [31:0] S1_LO = 32'h8400_0000;
  localparam logic [31:0] S2_LO = 32'h8800_0000;
  localparam logic [31:0] S2_HI = 32'h8C00_0000;
  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_WWAIT    = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_WRITE    = 3'd3;
  localparam logic [2:0] ST_WRITEP   = 3'd4;
  localparam logic [2:0] ST_RENABLE  = 3'd5;
  localparam logic [2:0] ST_WENABLE  = 3'd6;
  localparam logic [2:0] ST_WENABLEP = 3'd7;
  function automatic logic [2:0] sel_of(input logic [31:0] a);
    return (a >= S0_LO && a < S1_LO) ? 3'b001 :
           (a >= S1_LO && a < S2_LO) ? 3'b010 :
           (a >= S2_LO && a < S2_HI) ? 3'b100 : 3'b000;
  endfunction
endpackage

// File: rtl/bridge_if.sv
// bridge_if: AHB-Lite slave side and APB master side signals of the bridge
interface bridge_if;
  logic        Hwrite;
  logic        Hreadyin;
  logic [31:0] Hwdata;
  logic [31:0] Haddr;
  logic [1:0]  Htrans;
  logic [31:0] Prdata;
  logic        Penable;
  logic        Pwrite;
  logic [2:0]  Pselx;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  modport master (
    output Hwrite, Hreadyin, Hwdata, Haddr, Htrans, Prdata,
    input  Penable, Pwrite, Pselx, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
  );
  modport slave (
    input  Hwrite, Hreadyin, Hwdata, Haddr, Htrans, Prdata,
    output Penable, Pwrite, Pselx, Paddr, Pwdata, Hreadyout, Hresp, Hrdata
  );
endinterface

// File: rtl/bridge_ahb_slave_if.sv
// ahb_slave_if: AHB address/data pipeline, transfer qualification and slave decode
module ahb_slave_if
  import bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetin,
  input  logic        Hwrite,
  input  logic        Hreadyin,
  input  logic [1:0]  Htrans,
  input  logic [31:0] Haddr,
  input  logic [31:0] Hwdata,
  output logic        valid,
  output logic        Hwritereg,
  output logic [31:0] Haddr1,
  output logic [31:0] Haddr2,
  output logic [31:0] Hwdata1,
  output logic [2:0]  tempselx
);
  always_ff @(posedge Hclk or negedge Hresetin)
    if (!Hresetin) begin
      Haddr1    <= '0;
      Haddr2    <= '0;
      Hwdata1   <= '0;
      Hwritereg <= 1'b0;
    end else begin
      Haddr1    <= Haddr;
      Haddr2    <= Haddr1;
      Hwdata1   <= Hwdata;
      Hwritereg <= Hwrite;
    end
  always_comb begin
    tempselx = sel_of(Haddr);
    valid    = Hreadyin && (Htrans == HT_NONSEQ || Htrans == HT_SEQ) && Haddr >= S0_LO && Haddr < S2_HI;
  end
endmodule

// File: rtl/bridge_apb_controller.sv
// apb_controller: two-phase APB sequencer with registered APB outputs and AHB stall
module apb_controller
  import bridge_pkg::*;
(
  input  logic        Hclk,
  input  logic        Hresetin,
  input  logic        valid,
  input  logic        Hwrite,
  input  logic        Hwritereg,
  input  logic [31:0] Haddr,
  input  logic [31:0] Haddr1,
  input  logic [31:0] Haddr2,
  input  logic [31:0] Hwdata,
  input  logic [31:0] Hwdata1,
  input  logic [2:0]  tempselx,
  output logic        Penable,
  output logic        Pwrite,
  output logic [2:0]  Pselx,
  output logic [31:0] Paddr,
  output logic [31:0] Pwdata,
  output logic        Hreadyout
);
  logic [2:0] state, next;
  always_comb begin
    next = ST_IDLE;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: next = !valid ? ST_IDLE : Hwrite ? ST_WWAIT : ST_READ;
      ST_WWAIT:    next = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next = ST_RENABLE;
      ST_WRITE:    next = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next = ST_WENABLEP;
      ST_WENABLEP: next = !Hwritereg ? ST_READ : valid ? ST_WRITEP : ST_WRITE;
      default:     next = ST_IDLE;
    endcase
  end
  // outputs are loaded on the transition into the next state
  always_ff @(posedge Hclk or negedge Hresetin)
    if (!Hresetin) begin
      state     <= ST_IDLE;
      Paddr     <= '0;
      Pwdata    <= '0;
      Pwrite    <= 1'b0;
      Penable   <= 1'b0;
      Pselx     <= '0;
      Hreadyout <= 1'b1;
    end else begin
      state <= next;
      case (next)
        ST_READ: begin
          Paddr     <= Haddr;
          Pwrite    <= 1'b0;
          Pselx     <= tempselx;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          Paddr     <= state == ST_WWAIT ? Haddr1 : Haddr2;
          Pwdata    <= state == ST_WWAIT ? Hwdata : Hwdata1;
          Pwrite    <= 1'b1;
          Pselx     <= tempselx;
          Penable   <= 1'b0;
          Hreadyout <= 1'b0;
        end
        ST_RENABLE, ST_WENABLE, ST_WENABLEP: begin
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
        end
        default: begin
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
        end
      endcase
    end
endmodule

// File: rtl/bridge_top.sv
// bridge_top: AHB-Lite to APB bridge for three APB peripherals
module bridge_top
  import bridge_pkg::*;
(
  input logic     Hclk,
  input logic     Hresetin,
  bridge_if.slave bus
);
  logic        valid, Hwritereg;
  logic [31:0] Haddr1, Haddr2, Hwdata1;
  logic [2:0]  tempselx;
  ahb_slave_if u_ahb (
    .Hclk(Hclk), .Hresetin(Hresetin), .Hwrite(bus.Hwrite), .Hreadyin(bus.Hreadyin),
    .Htrans(bus.Htrans), .Haddr(bus.Haddr), .Hwdata(bus.Hwdata), .valid(valid),
    .Hwritereg(Hwritereg), .Haddr1(Haddr1), .Haddr2(Haddr2), .Hwdata1(Hwdata1),
    .tempselx(tempselx)
  );
  apb_controller u_apb (
    .Hclk(Hclk), .Hresetin(Hresetin), .valid(valid), .Hwrite(bus.Hwrite),
    .Hwritereg(Hwritereg), .Haddr(bus.Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
    .Hwdata(bus.Hwdata), .Hwdata1(Hwdata1), .tempselx(tempselx), .Penable(bus.Penable),
    .Pwrite(bus.Pwrite), .Pselx(bus.Pselx), .Paddr(bus.Paddr), .Pwdata(bus.Pwdata),
    .Hreadyout(bus.Hreadyout)
  );
  assign bus.Hresp  = 2'b00;
  assign bus.Hrdata = bus.Prdata;
endmodule

// File: tb/tb_bridge_top.sv
// tb_bridge_top: directed and random AHB transfers checked against an APB transaction model
module tb_bridge_top;
  typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] trans; logic wr; } beat_t;
  typedef struct { logic [2:0] sel; logic [31:0] addr; logic [31:0] data; logic wr; } xfer_t;
  logic Hclk = 1'b0;
  logic Hresetin = 1'b0;
  bridge_if bus();
  bridge_top dut (.Hclk(Hclk), .Hresetin(Hresetin), .bus(bus));
  always #5 Hclk = ~Hclk;
  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    return a == 32'h8400_0004 ? 32'h1234_5678 : (a ^ 32'hA5A5_0000) + 32'h13;
  endfunction
  assign bus.Hreadyin = bus.Hreadyout;
  assign bus.Prdata   = slave_rd(bus.Paddr);
  beat_t beats[$];
  xfer_t got[$], exp_q[$];
  int passed = 0, total = 0, fails = 0, lows = 0, viol = 0;
  logic [2:0] prev_sel = 3'b000;
  logic prev_pen = 1'b0;
  // APB monitor: one record per ENABLE phase, plus protocol rule tracking
  always @(negedge Hclk) begin
    if (bus.Penable) begin
      if (prev_sel != bus.Pselx || prev_sel == 3'b000 || prev_pen) viol++;
      got.push_back('{bus.Pselx, bus.Paddr, bus.Pwrite ? bus.Pwdata : bus.Hrdata, bus.Pwrite});
    end
    if (bus.Hresp !== 2'b00) viol++;
    if (!bus.Hreadyout) lows++;
    prev_sel = bus.Pselx;
    prev_pen = bus.Penable;
  end
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_penable"}, 32'(bus.Penable), 0);
    chk({tag, "_pwrite"}, 32'(bus.Pwrite), 0);
    chk({tag, "_pselx"}, 32'(bus.Pselx), 0);
    chk({tag, "_paddr"}, bus.Paddr, 0);
    chk({tag, "_pwdata"}, bus.Pwdata, 0);
    chk({tag, "_hreadyout"}, 32'(bus.Hreadyout), 1);
    chk({tag, "_hresp"}, 32'(bus.Hresp), 0);
  endtask
  task automatic drive(input int i);
    bus.Haddr  = beats[i].addr;
    bus.Htrans = beats[i].trans;
    bus.Hwrite = beats[i].wr;
  endtask
  // AHB master honouring Hready, then expected APB transfers from the address map
  task automatic run_beats(input string tag);
    int a = 0, guard = 0;
    logic rdy;
    got.delete();
    exp_q.delete();
    lows = 0;
    foreach (beats[i])
      if (beats[i].trans[1] && beats[i].addr >= 32'h8000_0000 && beats[i].addr < 32'h8C00_0000)
        exp_q.push_back('{3'b001 << ((beats[i].addr - 32'h8000_0000) >> 26), beats[i].addr,
                          beats[i].wr ? beats[i].data : slave_rd(beats[i].addr), beats[i].wr});
    @(negedge Hclk);
    drive(0);
    rdy = bus.Hreadyout;
    while (a < beats.size() && guard < 200) begin
      @(negedge Hclk);
      guard++;
      if (rdy) begin
        bus.Hwdata = beats[a].data;
        a++;
        if (a < beats.size()) drive(a);
        else bus.Htrans = 2'b00;
      end
      rdy = bus.Hreadyout;
    end
    chk({tag, "_beats_accepted"}, a, beats.size());
    repeat (10) @(negedge Hclk);
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      chk($sformatf("%s_%0d_sel", tag, i), 32'(got[i].sel), 32'(exp_q[i].sel));
      chk($sformatf("%s_%0d_addr", tag, i), got[i].addr, exp_q[i].addr);
      chk($sformatf("%s_%0d_data", tag, i), got[i].data, exp_q[i].data);
      chk($sformatf("%s_%0d_wr", tag, i), 32'(got[i].wr), 32'(exp_q[i].wr));
    end
    chk({tag, "_ready_lows"}, lows, exp_q.size());
  endtask
  initial begin
    logic [31:0] edges [5] = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
    int seen;
    bus.Haddr = '0; bus.Htrans = 2'b00; bus.Hwrite = 1'b0; bus.Hwdata = '0;
    repeat (2) @(negedge Hclk);
    chk_reset("reset");
    Hresetin = 1'b1;
    beats = '{'{32'h8000_0010, 32'hDEAD_BEEF, 2'b10, 1'b1}};
    run_beats("single_write");
    beats = '{'{32'h8400_0004, 32'h0, 2'b10, 1'b0}};
    run_beats("single_read");
    beats.delete();
    for (int i = 0; i < 4; i++)
      beats.push_back('{32'h8800_0000 + 32'(4 * i), 32'(i + 1), i == 0 ? 2'b10 : 2'b11, 1'b1});
    run_beats("burst_write");
    beats = '{'{32'h9000_0000, 32'h1111_1111, 2'b10, 1'b1}};
    run_beats("miss_addr");
    beats = '{'{32'h8000_0000, 32'h2222_2222, 2'b00, 1'b1}};
    run_beats("miss_idle");
    for (int k = 0; k < 28; k++) begin
      beat_t b;
      int r;
      r = $urandom_range(0, 4);
      b.addr = r < 3 ? 32'h8000_0000 + 32'(r << 26) + ($urandom & 32'h03FF_FFFC) :
               r == 3 ? 32'h8C00_0000 + ($urandom & 32'h3FFF_FFFC) : ($urandom & 32'h7FFF_FFFC);
      b.trans = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
      if (k < 5) begin
        b.addr = edges[k];
        b.trans = 2'b10;
      end
      b.wr = 1'($urandom_range(0, 1));
      b.data = $urandom;
      beats = '{b};
      run_beats($sformatf("rnd%0d", k));
    end
    @(negedge Hclk);
    bus.Haddr = 32'h8000_0020; bus.Htrans = 2'b10; bus.Hwrite = 1'b1;
    @(negedge Hclk);
    bus.Htrans = 2'b00; bus.Hwdata = 32'hCAFE_F00D;
    seen = 0;
    for (int i = 0; i < 10 && seen == 0; i++) begin
      @(negedge Hclk);
      if (bus.Penable) seen = 1;
    end
    chk("abort_enable_seen", seen, 1);
    chk("abort_pwdata_loaded", bus.Pwdata, 32'hCAFE_F00D);
    #2 Hresetin = 1'b0;
    #1 chk_reset("abort_async");
    @(negedge Hclk);
    Hresetin = 1'b1;
    got.delete();
    repeat (6) @(negedge Hclk);
    chk("abort_no_completion", got.size(), 0);
    chk("protocol_violations", viol, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
